// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline issue controller: op-number map,
// writeback-op list and controller state encoding.
package pipeline_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 3;

    localparam logic [OP_W-1:0] OP_NOP             = 6'd0;
    localparam logic [OP_W-1:0] OP_ALU_FIRST       = 6'd1;
    localparam logic [OP_W-1:0] OP_ALU_S2_LAST     = 6'd8;
    localparam logic [OP_W-1:0] OP_ALU_S1_LAST     = 6'd14;
    localparam logic [OP_W-1:0] OP_LOAD_FIRST      = 6'd16;
    localparam logic [OP_W-1:0] OP_LOAD_NODEST     = 6'd19;
    localparam logic [OP_W-1:0] OP_LOAD_LAST       = 6'd22;
    localparam logic [OP_W-1:0] OP_STORE_FIRST     = 6'd24;
    localparam logic [OP_W-1:0] OP_STORE_LAST      = 6'd30;
    localparam logic [OP_W-1:0] OP_CTRL_FIRST      = 6'd32;
    localparam logic [OP_W-1:0] OP_CTRL_RD_A_FIRST = 6'd34;
    localparam logic [OP_W-1:0] OP_CTRL_RD_A_LAST  = 6'd39;
    localparam logic [OP_W-1:0] OP_CTRL_RD_B_FIRST = 6'd42;
    localparam logic [OP_W-1:0] OP_CTRL_LAST       = 6'd47;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // Ops that also write an updated address back into source_1.
    function automatic logic is_wb_op(input logic [OP_W-1:0] op);
        case (op)
            6'd17, 6'd18, 6'd21, 6'd22,
            6'd25, 6'd26, 6'd29, 6'd30: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/op_classifier.sv
// Combinational decode of an op number into its register-usage classes.
module op_classifier
    import pipeline_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            writes_dest,
    output logic            reads_s1,
    output logic            reads_s2,
    output logic            reads_dest,
    output logic            wb_s1,
    output logic            is_ctrl,
    output logic            is_load
);

    logic ctrl_reads;

    always_comb begin
        ctrl_reads  = (op >= OP_CTRL_RD_A_FIRST && op <= OP_CTRL_RD_A_LAST) ||
                      (op >= OP_CTRL_RD_B_FIRST && op <= OP_CTRL_LAST);
        // Op 19 sits in the load range but has no destination.
        writes_dest = op >= OP_ALU_FIRST && op <= OP_LOAD_LAST && op != OP_LOAD_NODEST;
        reads_s1    = (op >= OP_ALU_FIRST && op <= OP_ALU_S1_LAST) ||
                      (op >= OP_LOAD_FIRST && op <= OP_STORE_LAST) || ctrl_reads;
        reads_s2    = (op >= OP_ALU_FIRST && op <= OP_ALU_S2_LAST) || ctrl_reads;
        reads_dest  = op >= OP_STORE_FIRST && op <= OP_STORE_LAST;
        wb_s1       = is_wb_op(op);
        is_ctrl     = op >= OP_CTRL_FIRST && op <= OP_CTRL_LAST;
        is_load     = op >= OP_LOAD_FIRST && op <= OP_LOAD_LAST;
    end

endmodule

// File: rtl/pipeline_control.sv
// Issue controller: hands execute at most one op per cycle, holding back ops
// on busy registers and squashing wrong-path decode after a taken jump.
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int ALU_LATENCY  = 1,
    parameter int LOAD_LATENCY = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                dec_valid,
    input  logic [OP_W-1:0]     dec_operationnumber,
    input  logic [REG_W-1:0]    dec_destination,
    input  logic [REG_W-1:0]    dec_source_1,
    input  logic [REG_W-1:0]    dec_source_2,
    output logic                dec_ready,
    input  logic [2:0]          exec_pcjumpenable,
    output logic                issue_valid,
    output logic [OP_W-1:0]     issue_operationnumber,
    output logic [REG_W-1:0]    issue_destination,
    output logic [REG_W-1:0]    issue_source_1,
    output logic [REG_W-1:0]    issue_source_2,
    output logic                stall,
    output logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output state_t              state
);

    // Handshake: a decode entry transfers on a rising edge where dec_valid and
    // dec_ready are both high; decode holds the entry stable while dec_ready is low.

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [1:0] ALU_CNT  = 2'(ALU_LATENCY);
    localparam logic [1:0] LOAD_CNT = 2'(LOAD_LATENCY);

    state_t            state_next;
    logic [FC_W-1:0]   flush_cnt;
    logic [FC_W-1:0]   flush_cnt_next;
    logic [1:0]        counter [NUM_REGS];
    logic [NUM_REGS-1:0] blocking;
    logic              hazard;
    logic              accept;
    logic [1:0]        dest_lat;

    logic writes_dest, reads_s1, reads_s2, reads_dest, wb_s1, is_ctrl, is_load;

    op_classifier u_classifier (
        .op          (dec_operationnumber),
        .writes_dest (writes_dest),
        .reads_s1    (reads_s1),
        .reads_s2    (reads_s2),
        .reads_dest  (reads_dest),
        .wb_s1       (wb_s1),
        .is_ctrl     (is_ctrl),
        .is_load     (is_load)
    );

    // A counter of 1 retires on the coming edge, so only counts of 2+ block.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            blocking[r]  = counter[r] > 2'd1;
            busy_mask[r] = counter[r] != 2'd0;
        end
    end

    assign hazard = ((reads_s1 | wb_s1) & blocking[dec_source_1]) |
                    (reads_s2 & blocking[dec_source_2]) |
                    ((reads_dest | writes_dest) & blocking[dec_destination]);

    assign dest_lat = is_load ? LOAD_CNT : ALU_CNT;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        dec_ready      = 1'b0;
        accept         = 1'b0;
        case (state)
            RUN: begin
                dec_ready = !hazard;
                accept    = dec_valid && !hazard;
                if (accept && is_ctrl) state_next = BR_WAIT;
            end
            BR_WAIT: begin
                if (exec_pcjumpenable != 3'd0) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYCLES);
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                dec_ready      = 1'b1;
                flush_cnt_next = flush_cnt - FC_W'(1);
                if (flush_cnt <= FC_W'(1)) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign stall = dec_valid && !dec_ready && (state != FLUSH);
    assign flush = state == FLUSH;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || !accept) begin
            issue_valid           <= 1'b0;
            issue_operationnumber <= OP_NOP;
            issue_destination     <= '0;
            issue_source_1        <= '0;
            issue_source_2        <= '0;
        end else begin
            issue_valid           <= 1'b1;
            issue_operationnumber <= dec_operationnumber;
            issue_destination     <= dec_destination;
            issue_source_1        <= dec_source_1;
            issue_source_2        <= dec_source_2;
        end
    end

    // Destination latency wins if an op names the same register twice.
    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset_n)
                counter[r] <= 2'd0;
            else if (accept && writes_dest && dec_destination == REG_W'(r))
                counter[r] <= dest_lat;
            else if (accept && wb_s1 && dec_source_1 == REG_W'(r))
                counter[r] <= ALU_CNT;
            else if (counter[r] != 2'd0)
                counter[r] <= counter[r] - 2'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed bench for pipeline_control, checked against an
// edge-counting reference model with an issue scoreboard.
module tb_pipeline_control;
    import pipeline_pkg::*;

    localparam int ALU_L  = 1;
    localparam int LOAD_L = 2;
    localparam int FC     = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       dec_valid = 1'b0;
    logic [5:0] dec_operationnumber = '0;
    logic [2:0] dec_destination = '0;
    logic [2:0] dec_source_1 = '0;
    logic [2:0] dec_source_2 = '0;
    logic [2:0] exec_pcjumpenable = '0;
    logic       dec_ready;
    logic       issue_valid;
    logic [5:0] issue_operationnumber;
    logic [2:0] issue_destination;
    logic [2:0] issue_source_1;
    logic [2:0] issue_source_2;
    logic       stall;
    logic       flush;
    logic [7:0] busy_mask;
    state_t     state;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    // Model: edge at which each register may next be used, and last branch.
    int   busy_end [8] = '{default: 0};
    int   br_edge = -100;
    logic br_taken = 1'b0;
    logic [30:0] exp_q [$];

    logic       obs_ready, obs_stall, obs_flush;
    logic [7:0] obs_mask;

    pipeline_control #(
        .NUM_REGS(8), .ALU_LATENCY(ALU_L), .LOAD_LATENCY(LOAD_L), .FLUSH_CYCLES(FC)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .dec_valid             (dec_valid),
        .dec_operationnumber   (dec_operationnumber),
        .dec_destination       (dec_destination),
        .dec_source_1          (dec_source_1),
        .dec_source_2          (dec_source_2),
        .dec_ready             (dec_ready),
        .exec_pcjumpenable     (exec_pcjumpenable),
        .issue_valid           (issue_valid),
        .issue_operationnumber (issue_operationnumber),
        .issue_destination     (issue_destination),
        .issue_source_1        (issue_source_1),
        .issue_source_2        (issue_source_2),
        .stall                 (stall),
        .flush                 (flush),
        .busy_mask             (busy_mask),
        .state                 (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- op classes from the op table ----------------
    function automatic logic m_wd(input logic [5:0] op);
        return op inside {[6'd1:6'd18], [6'd20:6'd22]};
    endfunction
    function automatic logic m_rs1(input logic [5:0] op);
        return op inside {[6'd1:6'd14], [6'd16:6'd30], [6'd34:6'd39], [6'd42:6'd47]};
    endfunction
    function automatic logic m_rs2(input logic [5:0] op);
        return op inside {[6'd1:6'd8], [6'd34:6'd39], [6'd42:6'd47]};
    endfunction
    function automatic logic m_rd(input logic [5:0] op);
        return op inside {[6'd24:6'd30]};
    endfunction
    function automatic logic m_wb(input logic [5:0] op);
        return op inside {6'd17, 6'd18, 6'd21, 6'd22, 6'd25, 6'd26, 6'd29, 6'd30};
    endfunction
    function automatic logic m_ctrl(input logic [5:0] op);
        return op inside {[6'd32:6'd47]};
    endfunction
    function automatic logic m_load(input logic [5:0] op);
        return op inside {[6'd16:6'd22]};
    endfunction
    function automatic logic blk(input logic [2:0] r, input int nxt);
        return nxt < busy_end[r];
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive just after a rising edge, check at the falling edge,
    // then commit the model at the next rising edge.
    task automatic step(input logic v, input logic [5:0] op, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] jmp,
                        output logic consumed);
        int nxt;
        logic brw, fl, haz, rdy, acc;
        logic [7:0] mask;
        dec_valid = v;
        dec_operationnumber = op;
        dec_destination = d;
        dec_source_1 = s1;
        dec_source_2 = s2;
        exec_pcjumpenable = jmp;
        @(negedge clock);
        nxt = edge_cnt + 1;
        brw = (nxt == br_edge + 1);
        fl  = br_taken && (nxt >= br_edge + 2) && (nxt <= br_edge + 1 + FC);
        haz = ((m_rs1(op) || m_wb(op)) && blk(s1, nxt)) ||
              (m_rs2(op) && blk(s2, nxt)) ||
              ((m_rd(op) || m_wd(op)) && blk(d, nxt));
        rdy = fl ? 1'b1 : (brw ? 1'b0 : !haz);
        acc = v && rdy && !fl;
        for (int r = 0; r < 8; r++) mask[r] = edge_cnt < busy_end[r];
        obs_ready = dec_ready;
        obs_stall = stall;
        obs_flush = flush;
        obs_mask  = busy_mask;
        check("dec_ready", 32'(dec_ready), 32'(rdy));
        check("stall", 32'(stall), 32'(v && !rdy && !fl));
        check("flush", 32'(flush), 32'(fl));
        check("busy_mask", 32'(busy_mask), 32'(mask));
        if (acc) exp_q.push_back({16'(nxt), op, d, s1, s2});
        consumed = v && rdy;
        @(posedge clock);
        if (acc) begin
            if (m_wb(op)) busy_end[s1] = nxt + ALU_L;
            if (m_wd(op)) busy_end[d] = nxt + (m_load(op) ? LOAD_L : ALU_L);
            if (m_ctrl(op)) begin
                br_edge  = nxt;
                br_taken = 1'b0;
            end
        end
        if (brw) br_taken = (jmp != 3'd0);
        #1;
    endtask

    task automatic idle(input int n);
        logic c;
        repeat (n) step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, c);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        dec_valid = 1'b0;
        exec_pcjumpenable = 3'd0;
        @(negedge clock);
        repeat (n) @(posedge clock);
        for (int r = 0; r < 8; r++) busy_end[r] = 0;
        br_edge  = -100;
        br_taken = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("rst_state", 32'(state), 32'(RUN));
        check("rst_busy_mask", 32'(busy_mask), 32'd0);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_fields", 32'({issue_operationnumber, issue_destination,
              issue_source_1, issue_source_2}), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [30:0] item;
        if (issue_valid) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 32'(issue_valid), 32'd0);
            end else begin
                item = exp_q.pop_front();
                check("issue_word", 32'({16'(edge_cnt), issue_operationnumber, issue_destination,
                      issue_source_1, issue_source_2}), 32'(item));
            end
        end else begin
            check("idle_nop", 32'(issue_operationnumber), 32'd0);
            if (exp_q.size() > 0 && int'(exp_q[0][30:15]) <= edge_cnt) begin
                check("issue_missing", 32'(issue_valid), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic c;
        logic rv;
        logic [5:0] rop;
        logic [2:0] rd, rs1, rs2, rj;
        logic have;

        do_reset(3);

        // Back-to-back RAW on an ALU result.
        step(1'b1, 6'd1, 3'd1, 3'd2, 3'd3, 3'd0, c);
        step(1'b1, 6'd1, 3'd4, 3'd1, 3'd0, 3'd0, c);
        check("t1_b2b_ready", 32'(obs_ready), 32'd1);
        idle(3);

        // Load-use hazard.
        step(1'b1, 6'd20, 3'd5, 3'd0, 3'd0, 3'd0, c);
        step(1'b1, 6'd2, 3'd7, 3'd5, 3'd6, 3'd0, c);
        check("t2_stall", 32'(obs_stall), 32'd1);
        check("t2_mask5", 32'(obs_mask[5]), 32'd1);
        step(1'b1, 6'd2, 3'd7, 3'd5, 3'd6, 3'd0, c);
        check("t2_accept", 32'(obs_ready), 32'd1);
        idle(3);

        // Taken jump: two wrong-path entries dropped, third issues.
        step(1'b1, 6'd34, 3'd0, 3'd0, 3'd0, 3'd0, c);
        step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd1, c);
        step(1'b1, 6'd1, 3'd2, 3'd3, 3'd4, 3'd0, c);
        check("t3_flush1", 32'(obs_flush), 32'd1);
        step(1'b1, 6'd1, 3'd2, 3'd3, 3'd4, 3'd0, c);
        check("t3_flush2", 32'(obs_flush), 32'd1);
        step(1'b1, 6'd1, 3'd2, 3'd3, 3'd4, 3'd0, c);
        check("t3_third_ready", 32'(obs_ready), 32'd1);
        check("t3_third_noflush", 32'(obs_flush), 32'd0);
        idle(3);

        // Not-taken jump: one dead cycle.
        step(1'b1, 6'd34, 3'd0, 3'd0, 3'd0, 3'd0, c);
        step(1'b1, 6'd3, 3'd1, 3'd2, 3'd3, 3'd0, c);
        check("t4_dead_stall", 32'(obs_stall), 32'd1);
        step(1'b1, 6'd3, 3'd1, 3'd2, 3'd3, 3'd0, c);
        check("t4_accept", 32'(obs_ready), 32'd1);
        check("t4_noflush", 32'(obs_flush), 32'd0);
        idle(3);

        // Load with writeback, then a WAW/RAW dependent op.
        step(1'b1, 6'd22, 3'd1, 3'd6, 3'd0, 3'd0, c);
        step(1'b1, 6'd9, 3'd6, 3'd1, 3'd2, 3'd0, c);
        check("t5_mask", 32'(obs_mask), 32'h42);
        check("t5_stall", 32'(obs_stall), 32'd1);
        step(1'b1, 6'd9, 3'd6, 3'd1, 3'd2, 3'd0, c);
        check("t5_mask6_clear", 32'(obs_mask[6]), 32'd0);
        check("t5_accept", 32'(obs_ready), 32'd1);
        idle(3);

        // Reset in the middle of FLUSH, then reset with busy counters.
        step(1'b1, 6'd40, 3'd0, 3'd0, 3'd0, 3'd0, c);
        step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd5, c);
        step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, c);
        check("t6_in_flush", 32'(obs_flush), 32'd1);
        do_reset(1);
        step(1'b1, 6'd20, 3'd2, 3'd0, 3'd0, 3'd0, c);
        do_reset(1);

        // Random traffic; a stalled entry is held until decode sees it taken.
        have = 1'b0;
        rv = 1'b0; rop = '0; rd = '0; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset(2);
                have = 1'b0;
            end
            if (!have) begin
                rv  = $urandom_range(0, 4) != 0;
                rop = 6'($urandom_range(0, 50));
                rd  = 3'($urandom_range(0, 7));
                rs1 = 3'($urandom_range(0, 7));
                rs2 = 3'($urandom_range(0, 7));
            end
            rj = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            step(rv, rop, rd, rs1, rs2, rj, c);
            have = rv && !c;
        end

        idle(4);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
